// File: rtl/pep_regf_rd_arbiter.sv
// ============================================================================
// Module   : pep_regf_rd_arbiter
// Brief    : Two-requester arbiter for the PE_PBS regfile read port, with an
//            in-order tag FIFO steering returned words to their owner.
//            Define PEP_REGF_ARB_PRIO_EN for fixed priority (requester 0 wins).
// Revision : 1.0
// ============================================================================
`default_nettype none

module pep_regf_rd_arbiter #(
    parameter int REQ_W       = 32,
    parameter int COEF_NB     = 8,
    parameter int DATA_W      = 32,
    parameter int OUTST_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        s_rst_n,
    input  logic [1:0]                  req_vld,
    output logic [1:0]                  req_rdy,
    input  logic [2*REQ_W-1:0]          req,
    output logic                        arb_req_vld,
    input  logic                        arb_req_rdy,
    output logic [REQ_W-1:0]            arb_req,
    input  logic [COEF_NB-1:0]          rsp_avail,
    input  logic [COEF_NB*DATA_W-1:0]   rsp_data,
    input  logic                        rsp_last_word,
    output logic [2*COEF_NB-1:0]        out_avail,
    output logic [COEF_NB*DATA_W-1:0]   out_data,
    output logic [1:0]                  out_last_word,
    output logic                        err_unexp_rsp
);

    localparam int PTR_W = $clog2(OUTST_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic                   lock;
    logic                   lock_sel;
    logic                   last_grant;
    logic                   sel;
    logic [OUTST_DEPTH-1:0] tag_mem;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   push;
    logic                   pop;
    logic                   head;

    assign fifo_full  = (count == CNT_W'(OUTST_DEPTH));
    assign fifo_empty = (count == '0);
    assign head       = tag_mem[rd_ptr];

    // A stalled request keeps its owner so the regfile sees a stable request.
    always_comb begin
        if (lock) begin
            sel = lock_sel;
        end else begin
`ifdef PEP_REGF_ARB_PRIO_EN
            sel = ~req_vld[0] & req_vld[1];
`else
            if (req_vld == 2'b11) begin
                sel = ~last_grant;
            end else begin
                sel = ~req_vld[0] & req_vld[1];
            end
`endif
        end
    end

    always_comb begin
        req_rdy      = 2'b00;
        req_rdy[sel] = arb_req_rdy & ~fifo_full;
    end

    assign arb_req_vld = req_vld[sel] & ~fifo_full;
    assign arb_req     = sel ? req[2*REQ_W-1:REQ_W] : req[REQ_W-1:0];
    assign push        = arb_req_vld & arb_req_rdy;
    assign pop         = rsp_avail[0] & rsp_last_word & ~fifo_empty;

    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            lock          <= 1'b0;
            lock_sel      <= 1'b0;
            last_grant    <= 1'b1;
            tag_mem       <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            out_avail     <= '0;
            out_data      <= '0;
            out_last_word <= 2'b00;
            err_unexp_rsp <= 1'b0;
        end else begin
            if (push) begin
                tag_mem[wr_ptr] <= sel;
                wr_ptr          <= wr_ptr + 1'b1;
                last_grant      <= sel;
                lock            <= 1'b0;
            end else if (arb_req_vld) begin
                lock     <= 1'b1;
                lock_sel <= sel;
            end

            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            // Responses arriving with no outstanding tag are dropped and flagged.
            if (fifo_empty) begin
                out_avail <= '0;
            end else if (head) begin
                out_avail <= {rsp_avail, {COEF_NB{1'b0}}};
            end else begin
                out_avail <= {{COEF_NB{1'b0}}, rsp_avail};
            end

            if (rsp_avail[0]) begin
                out_data <= rsp_data;
            end

            out_last_word       <= 2'b00;
            out_last_word[head] <= pop;
            err_unexp_rsp       <= rsp_avail[0] & fifo_empty;
        end
    end

endmodule

`default_nettype wire
